// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: boot hold-off, hazard bubbles,
// branch redirect, IM/DM waits and DM watchdog. Optional counters: PIPE_PERF_CNT_EN.
module pipeline_ctrl #(
   parameter int BOOT_CYCLES = 4,
   parameter int BOOTWIDTH   = 3,
   parameter int TIMEOUT     = 1023,
   parameter int TOWIDTH     = 10,
   parameter int PERFWIDTH   = 32
) (
   input  logic clk,
   input  logic rst,
   input  logic hazard_bubble,
   input  logic branch_taken,
   input  logic im_busy,
   input  logic dm_busy,
   output logic pc_en,
   output logic ifid_en,
   output logic ifid_flush,
   output logic idex_en,
   output logic idex_flush,
   output logic exmem_en,
   output logic memwb_en,
   output logic wd_timeout
`ifdef PIPE_PERF_CNT_EN
   ,
   output logic [PERFWIDTH-1:0] stall_cycles,
   output logic [PERFWIDTH-1:0] flush_cycles,
   output logic [PERFWIDTH-1:0] dm_wait_cycles
`endif
);

   typedef enum logic [1:0] {
      ST_BOOT    = 2'd0,
      ST_RUN     = 2'd1,
      ST_DMWAIT  = 2'd2,
      ST_DISCARD = 2'd3
   } state_t;

   // Control word order: {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en}
   localparam logic [6:0] CTL_BOOT   = 7'b0010100;
   localparam logic [6:0] CTL_FREEZE = 7'b0000000;
   localparam logic [6:0] CTL_BRANCH = 7'b1111111;
   localparam logic [6:0] CTL_BUBBLE = 7'b0001111;
   localparam logic [6:0] CTL_IMWAIT = 7'b0111011;
   localparam logic [6:0] CTL_NORMAL = 7'b1101011;

   state_t               r_state;
   state_t               w_next_state;
   logic [BOOTWIDTH-1:0] r_boot_cnt;
   logic [TOWIDTH-1:0]   r_wait_cnt;
   logic [TOWIDTH-1:0]   w_wait_next;
   logic                 w_wd_hit;
   logic [6:0]           w_ctl;

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_BOOT;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state decode; DMWAIT with DM released follows the RUN rules
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_BOOT: begin
            if (r_boot_cnt == BOOTWIDTH'(0)) begin
               w_next_state = ST_RUN;
            end else begin
               w_next_state = ST_BOOT;
            end
         end
         ST_RUN, ST_DMWAIT: begin
            if (dm_busy) begin
               w_next_state = ST_DMWAIT;
            end else if (branch_taken && im_busy) begin
               w_next_state = ST_DISCARD;
            end else begin
               w_next_state = ST_RUN;
            end
         end
         ST_DISCARD: begin
            if (dm_busy || im_busy) begin
               w_next_state = ST_DISCARD;
            end else begin
               w_next_state = ST_RUN;
            end
         end
         default: begin
            w_next_state = ST_BOOT;
         end
      endcase
   end

   // Output decode; flush codes already imply enable is don't-care
   always_comb begin
      w_ctl = CTL_BOOT;
      case (r_state)
         ST_BOOT: begin
            w_ctl = CTL_BOOT;
         end
         ST_RUN, ST_DMWAIT: begin
            if (dm_busy) begin
               w_ctl = CTL_FREEZE;
            end else if (branch_taken) begin
               w_ctl = CTL_BRANCH;
            end else if (hazard_bubble) begin
               w_ctl = CTL_BUBBLE;
            end else if (im_busy) begin
               w_ctl = CTL_IMWAIT;
            end else begin
               w_ctl = CTL_NORMAL;
            end
         end
         ST_DISCARD: begin
            if (dm_busy) begin
               w_ctl = CTL_FREEZE;
            end else begin
               w_ctl = CTL_IMWAIT;
            end
         end
         default: begin
            w_ctl = CTL_BOOT;
         end
      endcase
   end

   assign {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en} = w_ctl;

   // Boot hold-off counter
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_boot_cnt <= BOOTWIDTH'(BOOT_CYCLES - 1);
      end else if (r_state == ST_BOOT && r_boot_cnt != BOOTWIDTH'(0)) begin
         r_boot_cnt <= r_boot_cnt - BOOTWIDTH'(1);
      end else begin
         r_boot_cnt <= r_boot_cnt;
      end
   end

   // DM wait counter next value; the RUN-side entry cycle counts as the first busy cycle
   always_comb begin
      w_wait_next = TOWIDTH'(0);
      w_wd_hit    = 1'b0;
      if (r_state == ST_DMWAIT && dm_busy) begin
         if (r_wait_cnt == TOWIDTH'(TIMEOUT)) begin
            w_wait_next = r_wait_cnt;
         end else begin
            w_wait_next = r_wait_cnt + TOWIDTH'(1);
         end
         w_wd_hit = (w_wait_next == TOWIDTH'(TIMEOUT));
      end else if (r_state == ST_RUN && dm_busy) begin
         w_wait_next = TOWIDTH'(1);
         w_wd_hit    = (w_wait_next == TOWIDTH'(TIMEOUT));
      end else begin
         w_wait_next = TOWIDTH'(0);
         w_wd_hit    = 1'b0;
      end
   end

   // Wait counter and sticky watchdog flag
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wait_cnt <= TOWIDTH'(0);
         wd_timeout <= 1'b0;
      end else begin
         r_wait_cnt <= w_wait_next;
         wd_timeout <= wd_timeout | w_wd_hit;
      end
   end

`ifdef PIPE_PERF_CNT_EN
   // Performance counters, free-running with natural wrap
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cycles   <= PERFWIDTH'(0);
         flush_cycles   <= PERFWIDTH'(0);
         dm_wait_cycles <= PERFWIDTH'(0);
      end else begin
         if (r_state != ST_BOOT && !pc_en) begin
            stall_cycles <= stall_cycles + PERFWIDTH'(1);
         end else begin
            stall_cycles <= stall_cycles;
         end
         if (r_state != ST_BOOT && ifid_flush) begin
            flush_cycles <= flush_cycles + PERFWIDTH'(1);
         end else begin
            flush_cycles <= flush_cycles;
         end
         if (r_state == ST_DMWAIT && dm_busy) begin
            dm_wait_cycles <= dm_wait_cycles + PERFWIDTH'(1);
         end else begin
            dm_wait_cycles <= dm_wait_cycles;
         end
      end
   end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl (TIMEOUT shortened to 8 for the watchdog case).
module tb_pipeline_ctrl;

   localparam logic [6:0] E_BOOT   = 7'b0010100;
   localparam logic [6:0] E_FREEZE = 7'b0000000;
   localparam logic [6:0] E_BRANCH = 7'b1111111;
   localparam logic [6:0] E_BUBBLE = 7'b0001111;
   localparam logic [6:0] E_IMWAIT = 7'b0111011;
   localparam logic [6:0] E_NORMAL = 7'b1101011;

   logic clk;
   logic rst;
   logic hazard_bubble;
   logic branch_taken;
   logic im_busy;
   logic dm_busy;
   logic pc_en;
   logic ifid_en;
   logic ifid_flush;
   logic idex_en;
   logic idex_flush;
   logic exmem_en;
   logic memwb_en;
   logic wd_timeout;

   int total;
   int bad;

   pipeline_ctrl #(
      .BOOT_CYCLES(4),
      .BOOTWIDTH(3),
      .TIMEOUT(8),
      .TOWIDTH(4),
      .PERFWIDTH(32)
   ) dut (
      .clk(clk),
      .rst(rst),
      .hazard_bubble(hazard_bubble),
      .branch_taken(branch_taken),
      .im_busy(im_busy),
      .dm_busy(dm_busy),
      .pc_en(pc_en),
      .ifid_en(ifid_en),
      .ifid_flush(ifid_flush),
      .idex_en(idex_en),
      .idex_flush(idex_flush),
      .exmem_en(exmem_en),
      .memwb_en(memwb_en),
      .wd_timeout(wd_timeout)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [6:0] exp_ctl, input logic exp_wd);
      logic [7:0] obs;
      logic [7:0] expv;
      obs  = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en, wd_timeout};
      expv = {exp_ctl, exp_wd};
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
      end
   endtask

   // Called just after a posedge: apply inputs, check at negedge, advance one cycle.
   task automatic step(input logic hb, input logic bt, input logic imb, input logic dmb,
                       input string tag, input logic [6:0] exp_ctl, input logic exp_wd);
      hazard_bubble = hb;
      branch_taken  = bt;
      im_busy       = imb;
      dm_busy       = dmb;
      @(negedge clk);
      check(tag, exp_ctl, exp_wd);
      @(posedge clk);
      #1;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst = 1'b1;
      hazard_bubble = 1'b0;
      branch_taken  = 1'b0;
      im_busy       = 1'b0;
      dm_busy       = 1'b0;
      #1 rst = 1'b0;
      #1 check("reset", E_BOOT, 1'b0);
      dm_busy = 1'b1;
      branch_taken = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("reset_held", E_BOOT, 1'b0);
      @(posedge clk);
      #1 rst = 1'b1;

      // Boot: exactly four frozen/flushed cycles, inputs ignored
      step(1'b0, 1'b0, 1'b0, 1'b0, "boot0", E_BOOT, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b1, "boot1_dm_ignored", E_BOOT, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b0, "boot2_in_ignored", E_BOOT, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, "boot3", E_BOOT, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, "run_first", E_NORMAL, 1'b0);

      // Load-use bubble
      step(1'b1, 1'b0, 1'b0, 1'b0, "bubble", E_BUBBLE, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, "after_bubble", E_NORMAL, 1'b0);

      // IM wait alone, and bubble+IM priority
      step(1'b0, 1'b0, 1'b1, 1'b0, "im_wait", E_IMWAIT, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, "after_im", E_NORMAL, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b0, "prio_bubble_im", E_BUBBLE, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, "after_prio", E_NORMAL, 1'b0);

      // Branch during IM wait -> DISCARD for 4 cycles
      step(1'b0, 1'b1, 1'b1, 1'b0, "br_im", E_BRANCH, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0, "discard0", E_IMWAIT, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b0, "discard1_hb", E_IMWAIT, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0, "discard2", E_IMWAIT, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, "discard3_last", E_IMWAIT, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, "after_discard", E_NORMAL, 1'b0);

      // Branch with IM ready stays in RUN
      step(1'b1, 1'b1, 1'b0, 1'b0, "br_plain", E_BRANCH, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, "after_br", E_NORMAL, 1'b0);

      // DM wait with a held branch: 5 frozen cycles, then the branch
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b1, 1'b0, 1'b1, "dm_br_freeze", E_FREEZE, 1'b0);
      end
      step(1'b0, 1'b1, 1'b0, 1'b0, "dm_br_release", E_BRANCH, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, "after_dm_br", E_NORMAL, 1'b0);

      // DM busy inside DISCARD freezes and stays in DISCARD
      step(1'b0, 1'b1, 1'b1, 1'b0, "br_im2", E_BRANCH, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b1, "discard_dm", E_FREEZE, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0, "discard_a", E_IMWAIT, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, "discard_b", E_IMWAIT, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, "after_discard2", E_NORMAL, 1'b0);

      // Watchdog: flag visible from the 9th busy cycle, then sticky
      for (int i = 1; i <= 10; i++) begin
         step(1'b0, 1'b0, 1'b0, 1'b1, $sformatf("wd_busy%0d", i), E_FREEZE, (i >= 9) ? 1'b1 : 1'b0);
      end
      step(1'b1, 1'b0, 1'b0, 1'b0, "dmwait_exit_bubble", E_BUBBLE, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b0, "wd_sticky", E_NORMAL, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b0, "wd_sticky2", E_NORMAL, 1'b1);

      // Asynchronous reset mid-operation
      dm_busy = 1'b1;
      #2 rst = 1'b0;
      #1 check("reset_async", E_BOOT, 1'b0);
      @(posedge clk);
      #1 rst = 1'b1;
      step(1'b0, 1'b0, 1'b0, 1'b0, "reboot0", E_BOOT, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, "reboot1", E_BOOT, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, "reboot2", E_BOOT, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, "reboot3", E_BOOT, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, "rerun", E_NORMAL, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
